// File: rtl/serial_rx_align_pkg.sv
// Shared constants and types for the serial receive aligner.
// Holds the default COM character, the FSM state encoding, the word width and
// a helper that packs a received byte into the {valid, data} lane format.
package serial_rx_align_pkg;

  localparam logic [7:0] COM_CHAR_DEF = 8'hBC;
  localparam int         WORD_W       = 8;
  localparam int         VLD_IDX      = 8;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_COUNT  = 2'd1,
    ST_ACTIVE = 2'd2
  } rx_state_e;

  // A COM on the lane is idle, not payload: it goes out with valid low.
  function automatic logic [WORD_W:0] fmt_word(input logic [WORD_W-1:0] cand,
                                               input logic [WORD_W-1:0] com);
    return (cand == com) ? {1'b0, com} : {1'b1, cand};
  endfunction

endpackage

// File: rtl/serial_rx_align_shift8.sv
// Bit-level front end of the aligner: 8-bit MSB-first shift register plus a
// free-running 3-bit bit counter. o_cand is the word that would be complete if
// the current input bit were the last bit of a word; o_boundary marks the
// cycle whose input bit closes a word at the locked alignment.
module serial_rx_align_shift8
  import serial_rx_align_pkg::*;
(
  input  logic              i_clk16,
  input  logic              i_reset,
  input  logic              i_serial,
  input  logic              i_clr_cnt,
  output logic [WORD_W-1:0] o_cand,
  output logic              o_boundary
);

  logic [WORD_W-1:0] r_sr;
  logic [2:0]        r_bit_cnt;

  assign o_cand     = {r_sr[WORD_W-2:0], i_serial};
  assign o_boundary = (r_bit_cnt == 3'd7);

  // Shift in one bit per clock; the counter is re-phased when a COM is found.
  always_ff @(posedge i_clk16) begin
    if (i_reset) begin
      r_sr      <= '0;
      r_bit_cnt <= 3'd0;
    end else begin
      r_sr      <= o_cand;
      r_bit_cnt <= i_clr_cnt ? 3'd0 : r_bit_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/serial_rx_align.sv
// Receive-side deserializer for one PHY serial lane.
// Searches for the COM character on any bit offset, requires COM_COUNT
// consecutive word-aligned COMs to lock, then emits one {valid, byte} word
// every 8 clocks with a one-cycle strobe. Lock is only dropped by reset.
// Optional: define SERIAL_RX_STATS_EN to add com_cnt, a saturating count of
// COM words received while locked.
module serial_rx_align
  import serial_rx_align_pkg::*;
#(
  parameter logic [7:0] COM_CHAR  = COM_CHAR_DEF,
  parameter int         COM_COUNT = 4
) (
  input  logic             clk16,
  input  logic             reset,
  input  logic             serial_in,
  output logic [WORD_W:0]  data_out,
  output logic             word_strobe,
`ifdef SERIAL_RX_STATS_EN
  output logic [7:0]       com_cnt,
`endif
  output logic             active
);

  localparam logic [3:0] COM_CNT_L = 4'(COM_COUNT);

  rx_state_e         r_state;
  logic [3:0]        r_com_seen;
  logic [WORD_W:0]   r_data;
  logic              r_strobe;
  logic              r_active;
  logic [WORD_W-1:0] w_cand;
  logic              w_boundary;
  logic              w_match;
  logic              w_clr_cnt;

  assign w_match   = (w_cand == COM_CHAR);
  // A COM found while searching defines the word phase from here on.
  assign w_clr_cnt = (r_state == ST_SEARCH) && w_match;

  serial_rx_align_shift8 u_shift (
    .i_clk16    (clk16),
    .i_reset    (reset),
    .i_serial   (serial_in),
    .i_clr_cnt  (w_clr_cnt),
    .o_cand     (w_cand),
    .o_boundary (w_boundary)
  );

  // Alignment FSM with registered lane outputs.
  always_ff @(posedge clk16) begin
    if (reset) begin
      r_state    <= ST_SEARCH;
      r_com_seen <= 4'd0;
      r_data     <= '0;
      r_strobe   <= 1'b0;
      r_active   <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        ST_SEARCH: begin
          if (w_match) begin
            r_com_seen <= 4'd1;
            if (COM_COUNT == 1) begin
              r_state  <= ST_ACTIVE;
              r_active <= 1'b1;
            end else begin
              r_state <= ST_COUNT;
            end
          end
        end
        ST_COUNT: begin
          if (w_boundary) begin
            if (w_match) begin
              r_com_seen <= r_com_seen + 4'd1;
              if (r_com_seen + 4'd1 == COM_CNT_L) begin
                r_state  <= ST_ACTIVE;
                r_active <= 1'b1;
              end
            end else begin
              // Broken run: restart the hunt from the next bit.
              r_com_seen <= 4'd0;
              r_state    <= ST_SEARCH;
            end
          end
        end
        ST_ACTIVE: begin
          if (w_boundary) begin
            r_data   <= fmt_word(w_cand, COM_CHAR);
            r_strobe <= 1'b1;
          end
        end
        default: r_state <= ST_SEARCH;
      endcase
    end
  end

`ifdef SERIAL_RX_STATS_EN
  logic [7:0] r_com_cnt;

  // Saturating count of idle COM words seen after lock.
  always_ff @(posedge clk16) begin
    if (reset) begin
      r_com_cnt <= 8'h00;
    end else if (r_state == ST_ACTIVE && w_boundary && w_match &&
                 r_com_cnt != 8'hFF) begin
      r_com_cnt <= r_com_cnt + 8'h01;
    end
  end

  assign com_cnt = r_com_cnt;
`endif

  assign data_out    = r_data;
  assign word_strobe = r_strobe;
  assign active      = r_active;

endmodule

// File: tb/tb_serial_rx_align.sv
// Bench for serial_rx_align. Each scenario is a bit stream sent after a reset;
// the expected lock point and word outputs are computed from the whole stream
// by scanning it for COM runs, then compared cycle by cycle.
module tb_serial_rx_align;

  localparam logic [7:0] COM = 8'hBC;
  localparam int         CC  = 4;

  logic       clk16 = 1'b0;
  logic       reset;
  logic       serial_in;
  logic [8:0] data_out;
  logic       word_strobe;
  logic       active;
`ifdef SERIAL_RX_STATS_EN
  logic [7:0] com_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  bit bits[$];

  always #5 clk16 = ~clk16;

  serial_rx_align #(.COM_CHAR(COM), .COM_COUNT(CC)) dut (
    .clk16       (clk16),
    .reset       (reset),
    .serial_in   (serial_in),
    .data_out    (data_out),
    .word_strobe (word_strobe),
`ifdef SERIAL_RX_STATS_EN
    .com_cnt     (com_cnt),
`endif
    .active      (active)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, expv);
  endtask

  // Byte formed by the 8 bits ending at stream index k (zeros before start).
  function automatic logic [7:0] win(input int k);
    logic [7:0] w = 8'h00;
    for (int i = 0; i < 8; i++) begin
      int idx = k - 7 + i;
      w = {w[6:0], (idx >= 0) ? bits[idx] : 1'b0};
    end
    return w;
  endfunction

  // Index of the bit whose edge enters lock, or -1 if the stream never locks.
  function automatic int find_lock();
    int n = bits.size();
    int start = 0;
    forever begin
      int k = start;
      bit ok = 1'b1;
      while (k < n && win(k) != COM) k++;
      if (k >= n) return -1;
      for (int m = 1; m < CC; m++) begin
        int j = k + 8 * m;
        if (j >= n) return -1;
        if (win(j) != COM) begin
          start = j + 1;
          ok = 1'b0;
          break;
        end
      end
      if (ok) return k + 8 * (CC - 1);
    end
  endfunction

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bits.push_back(b[i]);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    serial_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk16); #1;
      if (i == 0) begin
        chk("rst_data", 32'(data_out), 32'h000);
        chk("rst_act", 32'(active), 32'h0);
        chk("rst_stb", 32'(word_strobe), 32'h0);
`ifdef SERIAL_RX_STATS_EN
        chk("rst_cnt", 32'(com_cnt), 32'h0);
`endif
      end
    end
    reset = 1'b0;
  endtask

  task automatic run_stream(input int rst_cycles);
    int         lk;
    logic [8:0] e_data = 9'h000;
    int         e_cnt  = 0;
    do_reset(rst_cycles);
    lk = find_lock();
    for (int k = 0; k < bits.size(); k++) begin
      bit e_act, e_stb;
      serial_in = bits[k];
      @(posedge clk16); #1;
      e_act = (lk >= 0) && (k >= lk);
      e_stb = (lk >= 0) && (k > lk) && ((k - lk) % 8 == 0);
      if (e_stb) begin
        logic [7:0] w = win(k);
        e_data = (w == COM) ? {1'b0, COM} : {1'b1, w};
        if (w == COM && e_cnt < 255) e_cnt++;
      end
      chk("active", 32'(active), 32'(e_act));
      chk("strobe", 32'(word_strobe), 32'(e_stb));
      chk("data", 32'(data_out), 32'(e_data));
`ifdef SERIAL_RX_STATS_EN
      chk("com_cnt", 32'(com_cnt), 32'(e_cnt));
`endif
    end
  endtask

  initial begin
    reset = 1'b1;
    serial_in = 1'b0;

    // Basic lock then one payload byte.
    bits.delete();
    repeat (4) push_byte(COM);
    push_byte(8'h5A);
    run_stream(3);
    chk("t_lock_word", 32'(data_out), 32'h15A);

    // Broken run of three COMs does not lock; the next run of four does.
    bits.delete();
    repeat (3) push_byte(COM);
    push_byte(8'h11);
    repeat (4) push_byte(COM);
    push_byte(8'h22);
    run_stream(2);
    chk("t_relock_word", 32'(data_out), 32'h122);

    // Alignment on a bit offset of 3.
    bits.delete();
    bits.push_back(1'b1); bits.push_back(1'b0); bits.push_back(1'b1);
    repeat (4) push_byte(COM);
    push_byte(8'hA5);
    run_stream(1);
    chk("t_offset_word", 32'(data_out), 32'h1A5);

    // COM after lock goes out with valid low.
    bits.delete();
    repeat (4) push_byte(COM);
    push_byte(8'h5A);
    push_byte(COM);
    run_stream(1);
    chk("t_com_word", 32'(data_out), 32'h0BC);

    // Stop mid-word in lock; next scenario's reset lands mid-word.
    bits.delete();
    repeat (4) push_byte(COM);
    push_byte(8'h5A);
    repeat (3) bits.push_back(1'b1);
    run_stream(1);
    chk("t_mid_act", 32'(active), 32'h1);

    // After reset, three COMs are not enough to relock.
    bits.delete();
    repeat (3) push_byte(COM);
    push_byte(8'h5A);
    run_stream(1);
    chk("t_norelock", 32'(active), 32'h0);

    // Stream ends one bit short of a word, so reset coincides with a boundary.
    bits.delete();
    repeat (4) push_byte(COM);
    repeat (7) bits.push_back(1'b1);
    run_stream(1);
    do_reset(1);

    // Randomized streams: junk offset, possibly broken COM runs, mixed payload.
    for (int r = 0; r < 12; r++) begin
      int nj = $urandom_range(0, 12);
      bits.delete();
      for (int i = 0; i < nj; i++) bits.push_back(1'($urandom));
      for (int i = 0, nc = $urandom_range(3, 6); i < nc; i++)
        push_byte(($urandom_range(0, 5) == 0) ? 8'($urandom) : COM);
      for (int i = 0, np = $urandom_range(6, 15); i < np; i++)
        push_byte(($urandom_range(0, 3) == 0) ? COM : 8'($urandom));
      run_stream($urandom_range(1, 3));
    end

`ifdef SERIAL_RX_STATS_EN
    // Counter saturation.
    bits.delete();
    repeat (4) push_byte(COM);
    repeat (260) push_byte(COM);
    run_stream(1);
    chk("t_sat", 32'(com_cnt), 32'hFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
